multicycle_controller: RTL and testbench

//  Moore FSM controller for the multicycle RV32I datapath. Sequences fetch, decode, execute,

---
 rtl/riscv_pkg.sv | 61 ++++++
 rtl/multicycle_controller_alu_decoder.sv | 31 +++
 rtl/multicycle_controller.sv | 137 +++++++++++++
 tb/tb_multicycle_controller.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I datapath: opcodes, mux selects,
// ALU and immediate-format codes, plus the controller state encoding.
package riscv_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_J = 3'd3;
   localparam logic [2:0] IMM_U = 3'd4;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;

   localparam logic [1:0] SRCB_RS2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } alu_op_e;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
      S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR1, S_JALR2, S_LUI
   } state_e;

   function automatic logic [2:0] imm_src_of(input logic [6:0] op);
      case (op)
         OP_STORE:  imm_src_of = IMM_S;
         OP_BRANCH: imm_src_of = IMM_B;
         OP_JAL:    imm_src_of = IMM_J;
         OP_LUI:    imm_src_of = IMM_U;
         default:   imm_src_of = IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Maps the controller's coarse ALUOp plus instruction fields to ALUControl.
module alu_decoder
   import riscv_pkg::*;
(
   input  alu_op_e    alu_op_i,
   input  logic [2:0] funct3_i,
   input  logic       funct7b5_i,
   input  logic       op5_i,
   output logic [2:0] alu_control_o
);

   always_comb begin
      alu_control_o = ALU_ADD;
      case (alu_op_i)
         ALUOP_SUB: alu_control_o = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3_i)
               // Only R-type (op[5]=1) can request sub; addi ignores funct7b5.
               3'b000:  alu_control_o = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_control_o = ALU_SLT;
               3'b100:  alu_control_o = ALU_XOR;
               3'b110:  alu_control_o = ALU_OR;
               3'b111:  alu_control_o = ALU_AND;
               default: alu_control_o = ALU_ADD;
            endcase
         end
         default: alu_control_o = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the multicycle RV32I datapath; outputs decode from the
// current state, with reset overriding the state to FETCH and killing enables.
module multicycle_controller
   import riscv_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUControl,
   output logic [2:0] ImmSrc
);

   state_e  state_q, state_d, state_eff;
   alu_op_e alu_op;
   logic    pc_update, branch, ir_write, mem_write, reg_write;

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXECR;
               OP_ITYPE:          state_d = S_EXECI;
               OP_BRANCH:         state_d = S_BRANCH;
               OP_JAL:            state_d = S_JAL;
               OP_JALR:           state_d = S_JALR1;
               OP_LUI:            state_d = S_LUI;
               default:           state_d = S_FETCH;
            endcase
         end
         S_MEMADR:  state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD: state_d = S_MEMWB;
         S_EXECR, S_EXECI, S_JAL, S_JALR2, S_LUI: state_d = S_ALUWB;
         S_JALR1:   state_d = S_JALR2;
         default:   state_d = S_FETCH;
      endcase
   end

   // Reset makes the outputs look like FETCH immediately, not one edge later.
   assign state_eff = reset ? S_FETCH : state_q;

   always_comb begin
      pc_update = 1'b0;
      branch    = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      AdrSrc    = 1'b0;
      ResultSrc = RES_ALUOUT;
      ALUSrcA   = SRCA_PC;
      ALUSrcB   = SRCB_RS2;
      alu_op    = ALUOP_ADD;
      case (state_eff)
         S_FETCH: begin
            ir_write  = 1'b1;
            pc_update = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURES;
         end
         S_DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMADR, S_JALR1: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMREAD: AdrSrc = 1'b1;
         S_MEMWB: begin
            ResultSrc = RES_DATA;
            reg_write = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc    = 1'b1;
            mem_write = 1'b1;
         end
         S_EXECR: begin
            ALUSrcA = SRCA_RS1;
            alu_op  = ALUOP_FUNCT;
         end
         S_EXECI: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
            alu_op  = ALUOP_FUNCT;
         end
         S_ALUWB: reg_write = 1'b1;
         S_BRANCH: begin
            ALUSrcA = SRCA_RS1;
            alu_op  = ALUOP_SUB;
            branch  = 1'b1;
         end
         S_JAL, S_JALR2: begin
            ALUSrcA   = SRCA_OLDPC;
            ALUSrcB   = SRCB_FOUR;
            pc_update = 1'b1;
         end
         S_LUI: begin
            ALUSrcA = SRCA_ZERO;
            ALUSrcB = SRCB_IMM;
         end
         default: ;
      endcase
   end

   assign PCWrite  = ~reset & (pc_update | (branch & (Zero ^ funct3[0])));
   assign IRWrite  = ~reset & ir_write;
   assign MemWrite = ~reset & mem_write;
   assign RegWrite = ~reset & reg_write;
   assign ImmSrc   = imm_src_of(op);

   alu_decoder u_alu_dec (
      .alu_op_i      (alu_op),
      .funct3_i      (funct3),
      .funct7b5_i    (funct7b5),
      .op5_i         (op[5]),
      .alu_control_o (ALUControl)
   );

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized check of the multicycle controller against a per-instruction
// cycle-table model of the expected control outputs.
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       Zero;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
   logic [2:0] ALUControl, ImmSrc;

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      int pcw, adr, mw, irw, rw, rs, sa, sb, alu, imm;
   } exp_t;

   multicycle_controller dut (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   function automatic int n_cycles(input logic [6:0] o);
      case (o)
         7'b0000011, 7'b1100111: return 5;
         7'b0100011, 7'b0110011, 7'b0010011, 7'b0110111, 7'b1101111: return 4;
         7'b1100011: return 3;
         default: return 2;
      endcase
   endfunction

   function automatic int imm_of(input logic [6:0] o);
      case (o)
         7'b0100011: return 1;
         7'b1100011: return 2;
         7'b1101111: return 3;
         7'b0110111: return 4;
         default:    return 0;
      endcase
   endfunction

   // ALU result codes: add 0, sub 1, and 2, or 3, xor 4, slt 5.
   function automatic int alu_fn(input logic [6:0] o, input logic [2:0] f3, input logic f7);
      case (f3)
         3'd0: return (o[5] && f7) ? 1 : 0;
         3'd2: return 5;
         3'd4: return 4;
         3'd6: return 3;
         3'd7: return 2;
         default: return 0;
      endcase
   endfunction

   // Expected outputs for cycle k (1-based) of the instruction with these fields.
   function automatic exp_t model(input logic [6:0] o, input logic [2:0] f3,
                                  input logic f7, input logic z, input int k);
      exp_t e = '{default: 0};
      int last = n_cycles(o);
      e.imm = imm_of(o);
      if (k == 1) begin
         e.irw = 1; e.pcw = 1; e.sb = 2; e.rs = 2;
      end else if (k == 2) begin
         e.sa = 1; e.sb = 1;
      end else if (k == last && o != 7'b1100011) begin
         e.rw = 1;
         if (o == 7'b0000011) e.rs = 1;
         if (o == 7'b0100011) begin e.rw = 0; e.mw = 1; e.adr = 1; end
      end else begin
         case (o)
            7'b0000011, 7'b0100011: begin
               if (k == 3) begin e.sa = 2; e.sb = 1; end
               else e.adr = 1;
            end
            7'b0110011: begin e.sa = 2; e.alu = alu_fn(o, f3, f7); end
            7'b0010011: begin e.sa = 2; e.sb = 1; e.alu = alu_fn(o, f3, f7); end
            7'b1100011: begin e.sa = 2; e.alu = 1; e.pcw = int'(z ^ f3[0]); end
            7'b1101111: begin e.sa = 1; e.sb = 2; e.pcw = 1; end
            7'b1100111: begin
               if (k == 3) begin e.sa = 2; e.sb = 1; end
               else begin e.sa = 1; e.sb = 2; e.pcw = 1; end
            end
            7'b0110111: begin e.sa = 3; e.sb = 1; end
            default: ;
         endcase
      end
      return e;
   endfunction

   task automatic check_all(input string pfx, input exp_t e);
      chk({pfx, ".PCWrite"},    int'(PCWrite),    e.pcw);
      chk({pfx, ".AdrSrc"},     int'(AdrSrc),     e.adr);
      chk({pfx, ".MemWrite"},   int'(MemWrite),   e.mw);
      chk({pfx, ".IRWrite"},    int'(IRWrite),    e.irw);
      chk({pfx, ".RegWrite"},   int'(RegWrite),   e.rw);
      chk({pfx, ".ResultSrc"},  int'(ResultSrc),  e.rs);
      chk({pfx, ".ALUSrcA"},    int'(ALUSrcA),    e.sa);
      chk({pfx, ".ALUSrcB"},    int'(ALUSrcB),    e.sb);
      chk({pfx, ".ALUControl"}, int'(ALUControl), e.alu);
      chk({pfx, ".ImmSrc"},     int'(ImmSrc),     e.imm);
   endtask

   // Runs one instruction starting in FETCH; zf<0 randomizes Zero per cycle.
   task automatic run_instr(input logic [6:0] o, input logic [2:0] f3,
                            input logic f7, input int zf);
      exp_t e;
      op = o; funct3 = f3; funct7b5 = f7;
      for (int k = 1; k <= n_cycles(o); k++) begin
         Zero = (zf < 0) ? 1'($urandom_range(0, 1)) : 1'(zf);
         @(negedge clk);
         e = model(o, f3, f7, Zero, k);
         check_all($sformatf("op%b.c%0d", o, k), e);
         @(posedge clk); #1;
      end
   endtask

   logic [6:0] ops [10] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                            7'b1101111, 7'b1100111, 7'b0110111, 7'b1111111, 7'b0000000};

   initial begin
      exp_t e;
      reset = 1'b1; op = 7'b0000011; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0;
      // During reset: FETCH selects with all enables held low.
      @(negedge clk);
      e = model(7'b0000011, 3'd0, 1'b0, 1'b0, 1);
      e.irw = 0; e.pcw = 0;
      check_all("reset", e);
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;

      run_instr(7'b0000011, 3'd2, 1'b0, -1);  // lw
      run_instr(7'b0100011, 3'd2, 1'b0, -1);  // sw
      run_instr(7'b0110011, 3'd0, 1'b1, -1);  // sub
      run_instr(7'b0010011, 3'd0, 1'b1, -1);  // addi with funct7b5 set
      run_instr(7'b1100011, 3'd0, 1'b1, 1);   // beq taken
      run_instr(7'b1100011, 3'd0, 1'b1, 0);   // beq not taken
      run_instr(7'b1100011, 3'd1, 1'b0, 1);   // bne not taken
      run_instr(7'b1100011, 3'd1, 1'b0, 0);   // bne taken
      run_instr(7'b1100111, 3'd0, 1'b0, -1);  // jalr
      run_instr(7'b1111111, 3'd0, 1'b0, -1);  // unknown op

      // Abort a store in its MEMWRITE cycle.
      op = 7'b0100011; funct3 = 3'd2; funct7b5 = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("abort.MemWrite", int'(MemWrite), 0);
      chk("abort.AdrSrc",   int'(AdrSrc),   0);
      chk("abort.IRWrite",  int'(IRWrite),  0);
      @(posedge clk); #1 reset = 1'b0;
      run_instr(7'b0110011, 3'd7, 1'b0, -1);

      for (int i = 0; i < 300; i++)
         run_instr(ops[$urandom_range(0, 9)], 3'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)), -1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
